// File: rtl/rv_lsu_pkg.sv
// Shared definitions for the load/store unit: memory op and size encodings,
// LSU FSM states, the registered request control word and a size helper.
package rv_lsu_pkg;

  localparam logic [1:0] MEM_LOAD  = 2'b00;
  localparam logic [1:0] MEM_STORE = 2'b01;
  localparam logic [1:0] MEM_RSVD  = 2'b10;
  localparam logic [1:0] MEM_NOOP  = 2'b11;

  localparam logic [1:0] MEM_BYTE      = 2'b00;
  localparam logic [1:0] MEM_HALF_WORD = 2'b01;
  localparam logic [1:0] MEM_WORD      = 2'b10;
  localparam logic [1:0] MEM_DOUBLE    = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    RESP = 2'b11
  } lsu_state_t;

  // Request attributes kept across the transaction; the unsigned flag is
  // explicit instead of being folded into the op encoding.
  typedef struct packed {
    logic       is_store;
    logic [1:0] size;
    logic       is_unsigned;
  } lsu_ctrl_t;

  // Number of bytes touched by an access of the given size code.
  function automatic int size_bytes(input logic [1:0] size);
    return 1 << size;
  endfunction

endpackage

// File: rtl/rv_lsu_align.sv
// Combinational lane logic for the LSU: aligned address, byte enables,
// store data replication, load data extraction/extension and access checks.
module rv_lsu_align
  import rv_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
)
(
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [XLEN-1:0]   wdata,
  input  logic [XLEN-1:0]   rdata,
  output logic [ADDR_W-1:0] aligned_addr,
  output logic [XLEN/8-1:0] be,
  output logic [XLEN-1:0]   wdata_rep,
  output logic [XLEN-1:0]   rdata_ext,
  output logic              misaligned,
  output logic              size_illegal
);

  localparam int NB     = XLEN / 8;
  localparam int LANE_W = $clog2(NB);

  logic [LANE_W-1:0] lane;
  logic [XLEN-1:0]   shifted;
  logic              sign_bit;
  int                raw_bytes;
  int                nbytes;

  // Lane shift, byte-enable mask, replication and extension for one access.
  // The byte count is clamped to the bus width so an illegal DOUBLE on a
  // 32-bit bus still indexes inside the vectors.
  always_comb begin
    lane         = addr[LANE_W-1:0];
    raw_bytes    = size_bytes(size);
    nbytes       = (raw_bytes > NB) ? NB : raw_bytes;
    size_illegal = (XLEN == 32) && (size == MEM_DOUBLE);
    misaligned   = (addr[2:0] & 3'(raw_bytes - 1)) != 3'b000;

    aligned_addr             = addr;
    aligned_addr[LANE_W-1:0] = '0;

    be        = '0;
    wdata_rep = '0;
    for (int i = 0; i < NB; i++) begin
      be[i]              = (i >= int'(lane)) && (i < int'(lane) + nbytes);
      wdata_rep[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
    end

    shifted   = rdata >> {lane, 3'b000};
    sign_bit  = !is_unsigned && shifted[8*nbytes-1];
    rdata_ext = '0;
    for (int i = 0; i < XLEN; i++) begin
      rdata_ext[i] = (i < 8*nbytes) ? shifted[i] : sign_bit;
    end
  end

endmodule

// File: rtl/rv_lsu.sv
// Load/store unit: accepts one request from the MEM stage, runs a
// req/gnt/rvalid handshake to the data memory and returns a registered,
// extended response or an error for misaligned/illegal accesses.
module rv_lsu
  import rv_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NB = XLEN / 8;

  lsu_state_t        state;
  lsu_state_t        next_state;
  lsu_ctrl_t         ctrl_r;
  logic [ADDR_W-1:0] addr_r;

  logic              accept;
  logic              bad;

  logic [ADDR_W-1:0] al_addr;
  logic [1:0]        al_size;
  logic              al_unsigned;
  logic [ADDR_W-1:0] al_aligned;
  logic [NB-1:0]     al_be;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_rdata;
  logic              al_misaligned;
  logic              al_illegal;

  // The single align instance sees the live request while idle and the
  // registered request afterwards, when it extracts the returning load data.
  always_comb begin
    if (state == IDLE) begin
      al_addr     = req_addr;
      al_size     = req_size;
      al_unsigned = req_unsigned;
    end else begin
      al_addr     = addr_r;
      al_size     = ctrl_r.size;
      al_unsigned = ctrl_r.is_unsigned;
    end
  end

  rv_lsu_align #(
    .XLEN   (XLEN),
    .ADDR_W (ADDR_W)
  ) u_align (
    .addr         (al_addr),
    .size         (al_size),
    .is_unsigned  (al_unsigned),
    .wdata        (req_wdata),
    .rdata        (mem_rdata),
    .aligned_addr (al_aligned),
    .be           (al_be),
    .wdata_rep    (al_wdata),
    .rdata_ext    (al_rdata),
    .misaligned   (al_misaligned),
    .size_illegal (al_illegal)
  );

  // State register; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode: errors skip the memory, stores skip the read wait.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept)     next_state = bad ? RESP : REQ;
      REQ:  if (mem_gnt)    next_state = ctrl_r.is_store ? RESP : WAIT;
      WAIT: if (mem_rvalid) next_state = RESP;
      RESP: if (rsp_ready)  next_state = IDLE;
      default:              next_state = IDLE;
    endcase
  end

  // Request-side decode: ready is purely the idle state, NOOP and the
  // reserved op are swallowed without an accept.
  always_comb begin
    req_ready = (state == IDLE);
    accept    = req_ready && req_valid &&
                ((req_op == MEM_LOAD) || (req_op == MEM_STORE));
    bad       = al_misaligned || al_illegal;
  end

  // Registered memory and response outputs plus the captured request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      addr_r    <= '0;
      ctrl_r    <= '0;
    end else begin
      mem_req   <= (next_state == REQ);
      rsp_valid <= (next_state == RESP);
      if (accept) begin
        addr_r             <= req_addr;
        ctrl_r.is_store    <= (req_op == MEM_STORE);
        ctrl_r.size        <= req_size;
        ctrl_r.is_unsigned <= req_unsigned;
      end
      if (accept && !bad) begin
        mem_we    <= (req_op == MEM_STORE);
        mem_addr  <= al_aligned;
        mem_be    <= al_be;
        mem_wdata <= al_wdata;
      end
      if (accept && bad) begin
        rsp_err   <= 1'b1;
        rsp_rdata <= '0;
      end
      if ((state == REQ) && mem_gnt && ctrl_r.is_store) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= '0;
      end
      if ((state == WAIT) && mem_rvalid) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= al_rdata;
      end
    end
  end

endmodule

// File: tb/tb_rv_lsu.sv
// Directed bench for rv_lsu: one XLEN=32 and one XLEN=64 instance share the
// handshake inputs; sel64 routes the request and the observed outputs.
module tb_rv_lsu;

  logic        clk;
  logic        rst_n;
  logic        sel64;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_ready;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  logic        ready32, rsp_valid32, rsp_err32, mem_req32, mem_we32;
  logic [31:0] rdata32, maddr32, wdata32;
  logic [3:0]  be32;
  logic        ready64, rsp_valid64, rsp_err64, mem_req64, mem_we64;
  logic [63:0] rdata64, wdata64;
  logic [31:0] maddr64;
  logic [7:0]  be64;

  logic        obs_ready, obs_rsp_valid, obs_rsp_err, obs_mem_req, obs_mem_we;
  logic [63:0] obs_rdata, obs_wdata;
  logic [31:0] obs_maddr;
  logic [7:0]  obs_be;

  int vectors;
  int miscompares;

  rv_lsu #(.XLEN(32), .ADDR_W(32)) dut32 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid && !sel64),
    .req_ready    (ready32),
    .req_op       (req_op),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata[31:0]),
    .rsp_valid    (rsp_valid32),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rdata32),
    .rsp_err      (rsp_err32),
    .mem_req      (mem_req32),
    .mem_we       (mem_we32),
    .mem_addr     (maddr32),
    .mem_be       (be32),
    .mem_wdata    (wdata32),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata[31:0])
  );

  rv_lsu #(.XLEN(64), .ADDR_W(32)) dut64 (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid && sel64),
    .req_ready    (ready64),
    .req_op       (req_op),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid64),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rdata64),
    .rsp_err      (rsp_err64),
    .mem_req      (mem_req64),
    .mem_we       (mem_we64),
    .mem_addr     (maddr64),
    .mem_be       (be64),
    .mem_wdata    (wdata64),
    .mem_gnt      (mem_gnt),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata)
  );

  // Observe whichever instance is currently selected.
  always_comb begin
    if (sel64) begin
      obs_ready     = ready64;
      obs_rsp_valid = rsp_valid64;
      obs_rsp_err   = rsp_err64;
      obs_mem_req   = mem_req64;
      obs_mem_we    = mem_we64;
      obs_rdata     = rdata64;
      obs_wdata     = wdata64;
      obs_maddr     = maddr64;
      obs_be        = be64;
    end else begin
      obs_ready     = ready32;
      obs_rsp_valid = rsp_valid32;
      obs_rsp_err   = rsp_err32;
      obs_mem_req   = mem_req32;
      obs_mem_we    = mem_we32;
      obs_rdata     = {32'h0, rdata32};
      obs_wdata     = {32'h0, wdata32};
      obs_maddr     = maddr32;
      obs_be        = {4'h0, be32};
    end
  end

  // Free-running core clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it when it disagrees.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a request for one cycle starting at the current negedge.
  task automatic applyStimulus(input bit is64, input logic [1:0] op, input logic [1:0] size,
                               input bit uns, input logic [31:0] addr, input logic [63:0] wdata);
    sel64        = is64;
    req_op       = op;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    req_valid    = 1'b1;
  endtask

  // Best-case transaction: gnt and rvalid held high, response checked at
  // exactly exp_lat cycles after accept, then consumed.
  task automatic runTxn(input string tag, input bit is64, input logic [1:0] op,
                        input logic [1:0] size, input bit uns, input logic [31:0] addr,
                        input logic [63:0] wdata, input logic [63:0] rdata,
                        input logic [7:0] exp_be, input logic [31:0] exp_maddr,
                        input logic [63:0] exp_wdata, input logic [63:0] exp_rdata,
                        input bit exp_err, input int exp_lat);
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    rsp_ready  = 1'b0;
    applyStimulus(is64, op, size, uns, addr, wdata);
    checkOutput({tag, "_ready"}, 64'(obs_ready), 64'h1);
    for (int cyc = 1; cyc <= exp_lat; cyc++) begin
      @(negedge clk);
      if (cyc == 1) req_valid = 1'b0;
      if (cyc == 1 && !exp_err) begin
        checkOutput({tag, "_mreq"}, 64'(obs_mem_req), 64'h1);
        checkOutput({tag, "_we"}, 64'(obs_mem_we), 64'(op == 2'b01));
        checkOutput({tag, "_maddr"}, 64'(obs_maddr), 64'(exp_maddr));
        checkOutput({tag, "_be"}, 64'(obs_be), 64'(exp_be));
        if (op == 2'b01) checkOutput({tag, "_wdata"}, obs_wdata, exp_wdata);
      end else begin
        checkOutput({tag, "_mreq_lo"}, 64'(obs_mem_req), 64'h0);
      end
      if (cyc < exp_lat) checkOutput({tag, "_early"}, 64'(obs_rsp_valid), 64'h0);
    end
    checkOutput({tag, "_rvalid"}, 64'(obs_rsp_valid), 64'h1);
    checkOutput({tag, "_rdata"}, obs_rdata, exp_rdata);
    checkOutput({tag, "_err"}, 64'(obs_rsp_err), 64'(exp_err));
    checkOutput({tag, "_busy"}, 64'(obs_ready), 64'h0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput({tag, "_done"}, 64'({obs_rsp_valid, obs_ready}), 64'b01);
  endtask

  // Reset-state snapshot of the selected instance.
  task automatic checkReset(input string tag);
    checkOutput({tag, "_ctl"}, 64'({obs_ready, obs_rsp_valid, obs_rsp_err, obs_mem_req, obs_mem_we}),
                64'b10000);
    checkOutput({tag, "_be"}, 64'(obs_be), 64'h0);
    checkOutput({tag, "_maddr"}, 64'(obs_maddr), 64'h0);
    checkOutput({tag, "_wdata"}, obs_wdata, 64'h0);
    checkOutput({tag, "_rdata"}, obs_rdata, 64'h0);
  endtask

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed sequence.
  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst_n        = 1'b0;
    sel64        = 1'b0;
    req_valid    = 1'b0;
    req_op       = 2'b11;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = '0;
    req_wdata    = '0;
    rsp_ready    = 1'b0;
    mem_gnt      = 1'b0;
    mem_rvalid   = 1'b0;
    mem_rdata    = '0;

    repeat (2) @(negedge clk);
    checkReset("rst32");
    sel64 = 1'b1;
    #1 checkReset("rst64");
    sel64 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    runTxn("ldb32", 0, 2'b00, 2'b00, 0, 32'h1003, 64'h0, 64'h80FF_0000,
           8'h08, 32'h1000, 64'h0, 64'hFFFF_FF80, 0, 3);
    runTxn("sth32", 0, 2'b01, 2'b01, 0, 32'h2002, 64'h1234_ABCD, 64'h0,
           8'h0C, 32'h2000, 64'hABCD_ABCD, 64'h0, 0, 2);
    runTxn("misw32", 0, 2'b00, 2'b10, 0, 32'h3001, 64'h0, 64'h0,
           8'h00, 32'h0, 64'h0, 64'h0, 1, 1);
    runTxn("dbl32", 0, 2'b00, 2'b11, 0, 32'h3000, 64'h0, 64'h0,
           8'h00, 32'h0, 64'h0, 64'h0, 1, 1);
    runTxn("ldhu32", 0, 2'b00, 2'b01, 1, 32'h7002, 64'h0, 64'h8001_1234,
           8'h0C, 32'h7000, 64'h0, 64'h0000_8001, 0, 3);
    runTxn("stw32", 0, 2'b01, 2'b10, 0, 32'h7004, 64'hDEAD_BEEF, 64'h0,
           8'h0F, 32'h7004, 64'hDEAD_BEEF, 64'h0, 0, 2);
    runTxn("ldwu64", 1, 2'b00, 2'b10, 1, 32'h4004, 64'h0, 64'hF000_0000_0000_0000,
           8'hF0, 32'h4000, 64'h0, 64'h0000_0000_F000_0000, 0, 3);
    runTxn("ldws64", 1, 2'b00, 2'b10, 0, 32'h4004, 64'h0, 64'hF000_0000_0000_0000,
           8'hF0, 32'h4000, 64'h0, 64'hFFFF_FFFF_F000_0000, 0, 3);
    runTxn("stb64", 1, 2'b01, 2'b00, 0, 32'h5005, 64'h1122_3344_5566_77A5, 64'h0,
           8'h20, 32'h5000, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0, 0, 2);
    runTxn("sth64", 1, 2'b01, 2'b01, 0, 32'h5006, 64'h0000_0000_0000_BEEF, 64'h0,
           8'hC0, 32'h5000, 64'hBEEF_BEEF_BEEF_BEEF, 64'h0, 0, 2);
    runTxn("ldd64", 1, 2'b00, 2'b11, 0, 32'h6000, 64'h0, 64'h8123_4567_89AB_CDEF,
           8'hFF, 32'h6000, 64'h0, 64'h8123_4567_89AB_CDEF, 0, 3);
    runTxn("misd64", 1, 2'b00, 2'b11, 0, 32'h6004, 64'h0, 64'h0,
           8'h00, 32'h0, 64'h0, 64'h0, 1, 1);

    // NOOP and the reserved op are consumed without any activity.
    for (int k = 0; k < 2; k++) begin
      applyStimulus(0, (k == 0) ? 2'b11 : 2'b10, 2'b10, 0, 32'hA000, 64'h0);
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("noop", 64'({obs_ready, obs_mem_req, obs_rsp_valid}), 64'b100);
      @(negedge clk);
      checkOutput("noop_later", 64'({obs_ready, obs_mem_req, obs_rsp_valid}), 64'b100);
    end

    // Grant withheld 5 cycles (stray rvalid meanwhile), response held 3 cycles.
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h1111_2222;
    rsp_ready  = 1'b0;
    applyStimulus(0, 2'b00, 2'b01, 0, 32'h8002, 64'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      checkOutput("stall_mem", {22'h0, obs_mem_req, obs_mem_we, obs_be, obs_maddr},
                  {22'h0, 1'b1, 1'b0, 8'h0C, 32'h8000});
      checkOutput("stall_rsp", 64'({obs_ready, obs_rsp_valid}), 64'b00);
    end
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    mem_gnt = 1'b0;
    checkOutput("stall_wait", 64'({obs_mem_req, obs_rsp_valid, obs_ready}), 64'b000);
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h8765_0000;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 64'h0;
    checkOutput("stall_resp", {obs_rsp_valid, obs_rsp_err, obs_rdata[61:0]},
                {1'b1, 1'b0, 62'h0000_0000_FFFF_8765});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("hold_resp", {obs_rsp_valid, obs_rsp_err, obs_rdata[61:0]},
                  {1'b1, 1'b0, 62'h0000_0000_FFFF_8765});
      checkOutput("hold_ready", 64'(obs_ready), 64'h0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("stall_done", 64'({obs_rsp_valid, obs_ready}), 64'b01);

    // Reset while waiting for read data; a late rvalid must be ignored.
    mem_gnt    = 1'b1;
    mem_rvalid = 1'b0;
    applyStimulus(0, 2'b00, 2'b00, 1, 32'h9001, 64'h0);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst_n   = 1'b0;
    #1 checkReset("rst_wait");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    mem_rvalid = 1'b1;
    mem_rdata  = 64'h0000_AB00;
    @(negedge clk);
    mem_rvalid = 1'b0;
    checkOutput("late_rvalid", 64'({obs_ready, obs_mem_req, obs_rsp_valid}), 64'b100);
    @(negedge clk);
    runTxn("post_rst", 0, 2'b00, 2'b00, 1, 32'h9001, 64'h0, 64'h0000_AB00,
           8'h02, 32'h9000, 64'h0, 64'h0000_00AB, 0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
